// File: rtl/lsu_mem_exec.sv
// Load/store execution stage: sizes and aligns one issued memory op, runs the
// data-memory handshake, and broadcasts load results on the CDB.
// state | meaning
// IDLE  | waiting for an issued op from the queue head
// MEM   | memory request outstanding, timeout timer running
// WB    | load result requesting the CDB
// ERR   | one-cycle error report (misaligned, illegal funct3, timeout)
module lsu_mem_exec #(
    parameter int TAG_WIDTH   = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [31:0]          ex_address,
    input  logic [31:0]          ex_data,
    input  logic [TAG_WIDTH-1:0] rd_tag,
    input  logic                 rd_tag_valid,
    input  logic [2:0]           funct3,
    input  logic                 agu_ls,
    output logic                 ex_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic [TAG_WIDTH-1:0] cdb_tag,
    output logic [31:0]          cdb_data,
    output logic                 lsu_err,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB, S_ERR} state_t;

    state_t               state, state_nxt;
    logic [31:0]          addr_q, wdata_q, cdb_data_q, timer;
    logic [3:0]           be_q;
    logic [2:0]           f3_q;
    logic                 we_q, tag_valid_q;
    logic [TAG_WIDTH-1:0] tag_q;

    logic [1:0]  off;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, shifted, load_fmt;
    logic        legal_in, accept, timeout;

    assign off    = ex_address[1:0];
    assign accept = (state == S_IDLE) && issue_valid;

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = ex_data;
        case (funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << off;
                wdata_in = {4{ex_data[7:0]}};
            end
            2'b01: begin
                be_in    = off[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{ex_data[15:0]}};
            end
            default: ;
        endcase
        if (!agu_ls)
            be_in = 4'b1111;

        if (agu_ls)
            legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        if ((funct3[1:0] == 2'b01) && off[0])
            legal_in = 1'b0;
        if ((funct3[1:0] == 2'b10) && (off != 2'b00))
            legal_in = 1'b0;
    end

    always_comb begin
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
        load_fmt = mem_rdata;
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'd0, shifted[7:0]};
            3'b101:  load_fmt = {16'd0, shifted[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    // MEM_TIMEOUT of 0 disables the timeout entirely
    assign timeout = (MEM_TIMEOUT != 0) && (timer == 32'd0) && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ex_done   = 1'b0;
        lsu_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue_valid)
                    state_nxt = legal_in ? S_MEM : S_ERR;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (!we_q && tag_valid_q) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_IDLE;
                        ex_done   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB: begin
                if (cdb_grant) begin
                    state_nxt = S_IDLE;
                    ex_done   = 1'b1;
                end
            end
            S_ERR: begin
                lsu_err = 1'b1;
                if (!we_q && tag_valid_q) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_IDLE;
                    ex_done   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            timer       <= '0;
        end else begin
            if (accept) begin
                addr_q      <= ex_address;
                wdata_q     <= wdata_in;
                be_q        <= be_in;
                f3_q        <= funct3;
                we_q        <= agu_ls;
                tag_q       <= rd_tag;
                tag_valid_q <= rd_tag_valid;
                cdb_data_q  <= '0;
                timer       <= 32'(MEM_TIMEOUT - 1);
            end else if (state == S_MEM) begin
                if (mem_ready)
                    cdb_data_q <= load_fmt;
                else if (timer != 32'd0)
                    timer <= timer - 32'd1;
            end
        end
    end

    assign mem_req   = (state == S_MEM);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign cdb_req   = (state == S_WB);
    assign cdb_tag   = tag_q;
    assign cdb_data  = cdb_data_q;
    assign busy      = (state != S_IDLE);

endmodule
